// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings and state type for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - little-endian lane extraction for loads and lane merge for stores
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_pos;
    logic [4:0]  half_pos;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_pos = {addr_lo_i, 3'b000};
    assign half_pos = {addr_lo_i[1], 4'b0000};
    assign byte_v   = word_i[byte_pos +: 8];
    assign half_v   = word_i[half_pos +: 16];

    // Right-align and extend the addressed lane; splice store data into that lane only.
    always_comb begin
        load_o   = word_i;
        merged_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o   = {{24{signed_i & byte_v[7]}}, byte_v};
                merged_o = word_i;
                merged_o[byte_pos +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o   = {{16{signed_i & half_v[15]}}, half_v};
                merged_o = word_i;
                merged_o[half_pos +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o   = word_i;
                merged_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with read-modify-write for sub-word stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] read_addr,
    output logic [31:0] write_addr,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic        write_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rmw_q;
    logic        accept, req_err;
    logic [31:0] word_idx, align_word, load_val, merged_word;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    assign req_err   = (req_size == SZ_ILL)
                     | ((req_size == SZ_HALF) & req_addr[0])
                     | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                     | ({1'b0, req_addr} >= ADDR_LIMIT);

    assign word_idx   = {2'b00, addr_q[31:2]};
    assign align_word = (state_q == RMW_WR) ? rmw_q : read_data;

    lsu_align u_align (
        .word_i    (align_word),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .wdata_i   (wdata_q),
        .load_o    (load_val),
        .merged_o  (merged_word)
    );

    // Memory strobes and addresses are pure decodes of the state; idle buses read as zero.
    assign memread    = (state_q == LOAD) | (state_q == RMW_RD);
    assign memwrite   = (state_q == STORE) | (state_q == RMW_WR);
    assign read_addr  = memread ? word_idx : 32'h0;
    assign write_addr = memwrite ? word_idx : 32'h0;
    assign write_data = (state_q == STORE)  ? wdata_q :
                        (state_q == RMW_WR) ? merged_word : 32'h0;

    // Store and rejected responses report zero; otherwise the last load result stays visible.
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid & (write_q | err_q)) ? 32'h0 : rdata_q;

    // Next-state selection: errors skip memory entirely, sub-word stores go through RMW.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                  state_d = RESP;
                    else if (!req_write)          state_d = LOAD;
                    else if (req_size == SZ_WORD) state_d = STORE;
                    else                          state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            STORE:   state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request capture on acceptance, load result and RMW read word captured at end of their cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            rmw_q    <= 32'h0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                err_q    <= req_err;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == LOAD)   rdata_q <= load_val;
            if (state_q == RMW_RD) rmw_q   <= read_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, memread, memwrite;
    logic [31:0] resp_rdata, read_addr, write_addr, write_data, read_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cycle_cnt = 0;
    int          rd_cyc = 0;
    int          wr_cyc = 0;
    int          resp_cnt = 0;

    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h0;
    logic [31:0] pl_data = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .memread    (memread),
        .memwrite   (memwrite),
        .read_addr  (read_addr),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    assign read_data = mem[read_addr[7:0]];

    // Data memory model plus a preload port for the bench
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (memwrite)   mem[write_addr[7:0]] <= write_data;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: bus rules every cycle, and scoreboard pop on every response
    always @(negedge clk) begin
        if (!rst) begin
            if (memread)  rd_cyc++;
            if (memwrite) wr_cyc++;
            check("rd_wr_exclusive", 32'(memread & memwrite), 32'h0);
            if (!memread)  check("read_addr_idle", read_addr, 32'h0);
            if (!memwrite) check("write_bus_idle", write_addr | write_data, 32'h0);
            if (resp_valid) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got rdata %08h err %0d expected no response",
                             resp_rdata, resp_err);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("resp_latency", 32'(cycle_cnt - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_addr = 8'(a);
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input logic keep);
        int cyc;
        cyc = 0;
        @(negedge clk);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        while (!req_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_ready %0d expected 1", req_ready);
            req_valid = 1'b0;
        end else begin
            sb.push_back('{exp_rd, exp_err, lat, cycle_cnt + 1});
            @(posedge clk);
            #1;
            if (!keep) req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((sb.size() != 0 || !req_ready) && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (c >= 40) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding expected 0", sb.size());
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, w0, n0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        preload(0, 32'h12345678);
        preload(5, 32'h8899AABB);
        preload(7, 32'h11223344);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_memread", 32'(memread), 32'h0);
        check("rst_memwrite", 32'(memwrite), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Loads from word 5 = 8899AABB
        issue(1'b0, SZ_BYTE, 1'b1, 32'h16, 32'h0, 32'hFFFFFF99, 1'b0, 1, 1'b0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h16, 32'h0, 32'h00000099, 1'b0, 1, 1'b0);
        issue(1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, 32'hFFFF8899, 1'b0, 1, 1'b0);
        issue(1'b0, SZ_HALF, 1'b0, 32'h14, 32'h0, 32'h0000AABB, 1'b0, 1, 1'b0);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h14, 32'h0, 32'hFFFFFFBB, 1'b0, 1, 1'b0);
        issue(1'b0, SZ_WORD, 1'b1, 32'h14, 32'h0, 32'h8899AABB, 1'b0, 1, 1'b0);
        drain();

        // Byte store via read-modify-write
        issue(1'b1, SZ_BYTE, 1'b0, 32'h15, 32'h00000011, 32'h0, 1'b0, 2, 1'b0);
        @(negedge clk);
        check("rmw_rd_memread", 32'(memread), 32'h1);
        check("rmw_rd_read_addr", read_addr, 32'd5);
        @(negedge clk);
        check("rmw_wr_memwrite", 32'(memwrite), 32'h1);
        check("rmw_wr_write_addr", write_addr, 32'd5);
        check("rmw_wr_write_data", write_data, 32'h889911BB);
        drain();
        check("mem5_after_byte_store", mem[5], 32'h889911BB);

        // Half store to upper lane; upper store-data bits must be ignored
        issue(1'b1, SZ_HALF, 1'b0, 32'h1E, 32'hFFFF5678, 32'h0, 1'b0, 2, 1'b0);
        drain();
        check("mem7_after_half_store", mem[7], 32'h56783344);

        // Word store at the top word, then reload it
        w0 = wr_cyc;
        issue(1'b1, SZ_WORD, 1'b0, 32'h3FC, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b0);
        @(negedge clk);
        check("store_memwrite", 32'(memwrite), 32'h1);
        check("store_write_addr", write_addr, 32'd255);
        check("store_write_data", write_data, 32'hDEADBEEF);
        drain();
        check("store_single_write", 32'(wr_cyc - w0), 32'h1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, 32'hDEADBEEF, 1'b0, 1, 1'b0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h3FF, 32'h0, 32'h000000DE, 1'b0, 1, 1'b0);
        drain();

        // Rejected requests never touch memory
        r0 = rd_cyc;
        w0 = wr_cyc;
        issue(1'b0, SZ_HALF, 1'b0, 32'h003, 32'h0, 32'h0, 1'b1, 0, 1'b0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h400, 32'h12345678, 32'h0, 1'b1, 0, 1'b0);
        issue(1'b0, SZ_ILL, 1'b0, 32'h000, 32'h0, 32'h0, 1'b1, 0, 1'b0);
        drain();
        check("err_no_memread", 32'(rd_cyc - r0), 32'h0);
        check("err_no_memwrite", 32'(wr_cyc - w0), 32'h0);

        // Reset during RMW_RD aborts the half store
        w0 = wr_cyc;
        issue(1'b1, SZ_HALF, 1'b0, 32'h02, 32'h0000CAFE, 32'h0, 1'b0, 2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_memwrite", 32'(memwrite), 32'h0);
        check("abort_resp_valid", 32'(resp_valid), 32'h0);
        check("abort_req_ready", 32'(req_ready), 32'h1);
        sb.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(req_ready), 32'h1);
        repeat (5) @(negedge clk);
        check("abort_no_write", 32'(wr_cyc - w0), 32'h0);
        check("mem0_unchanged", mem[0], 32'h12345678);

        // Back-to-back with req_valid held high
        n0 = resp_cnt;
        issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 32'h889911BB, 1'b0, 1, 1'b1);
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h000000A5, 32'h0, 1'b0, 1, 1'b1);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 32'h000000A5, 1'b0, 1, 1'b0);
        drain();
        check("b2b_resp_count", 32'(resp_cnt - n0), 32'd3);
        check("rdata_held", resp_rdata, 32'h000000A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 256, word depth of the downstream data memory; legal byte addresses are 0 .. 4*MEM_WORDS-1.
REQ-002 Clock: one clock; reset is asynchronous and active-high. Ports: clk (in, 1, clock) and rst (in, 1, async active-high reset).
REQ-003 Ports:
- req_valid, in, 1: access request.
- req_ready, out, 1: unit idle, request accepted this cycle.
- req_write, in, 1: 1=store, 0=load.
- req_size, in, 2: 00 byte, 01 half, 10 word, 11 illegal.
- req_signed, in, 1: sign-extend loads.
- req_addr, in, 32: byte address.
- req_wdata, in, 32: store data, right-aligned.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_rdata, out, 32: load result.
- resp_err, out, 1: request rejected.
- memread, out, 1: data memory read enable.
- memwrite, out, 1: data memory write enable.
- read_addr, out, 32: word index.
- write_addr, out, 32: word index.
- write_data, out, 32: word to write.
- read_data, in, 32: combinational read word from data memory.

Function
REQ-004 Request is accepted when req_valid and req_ready are both 1 at a clk rising edge; the unit SHALL register all req_* fields on acceptance.
REQ-005 req_ready SHALL be 1 only in IDLE; requests presented while busy SHALL be ignored.
REQ-006 States SHALL be IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
REQ-007 Error detection: size 11, address misaligned (half with addr[0]=1, word with addr[1:0]!=0), or addr >= 4*MEM_WORDS SHALL go IDLE->RESP with resp_err=1, resp_rdata=0, and no memread/memwrite.
REQ-008 Word index SHALL be addr>>2, zero-extended to 32 bits, on read_addr and write_addr.
REQ-009 Load: IDLE->LOAD->RESP. In LOAD, memread=1; the extracted and extended value is captured at the end of the cycle. Accepted at edge N, resp_valid is high in cycle N+2.
REQ-010 Word store: IDLE->STORE->RESP. In STORE, memwrite=1 and write_data=req_wdata.
REQ-011 Byte or half store: IDLE->RMW_RD->RMW_WR->RESP.
- In RMW_RD, memread=1 and the read word is captured.
- In RMW_WR, memwrite=1 and write_data is the captured word with only the addressed lane replaced.
REQ-012 Lane mapping SHALL be little-endian.
- Byte lane k = addr[1:0] occupies bits 8k+7:8k.
- Half lane addr[1] occupies bits 16*addr[1]+15:16*addr[1].
REQ-013 Loads SHALL extract the addressed lane right-aligned; sign-extend if req_signed=1, else zero-extend. Word loads ignore req_signed.
REQ-014 RESP lasts exactly one cycle with resp_valid=1, then returns to IDLE. A new request MAY be accepted in the cycle after RESP.
REQ-015 resp_rdata SHALL hold its value until the next load response; store responses SHALL drive resp_rdata=0.
REQ-016 memread and memwrite SHALL never be 1 simultaneously. memwrite SHALL be high for exactly one cycle per successful store.
REQ-017 read_addr, write_addr and write_data SHALL be 0 whenever the corresponding enable is 0.

Reset
REQ-018 While rst=1, the unit SHALL be in IDLE, with req_ready=1 and all other outputs 0.
REQ-019 Reset asserted in any state SHALL abort the access immediately. A reset during RMW_RD or STORE SHALL prevent memwrite for that request, and no resp_valid SHALL be produced for the aborted request.

Structure
REQ-020 A shared package lsu_pkg SHALL hold:
- the size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD;
- the state enum.
REQ-021 Lane extraction and merge SHALL live in one combinational sub-module, lsu_align, instantiated once. Its inputs are the word, addr[1:0], size, signed flag and store data; its outputs are the extracted load value and the merged word.

Verification
REQ-022 Preload word 5 = 0x8899AABB.
- Load byte, signed, addr 0x16 -> resp_rdata=0xFFFFFF99 at N+2.
- Same access unsigned -> 0x00000099.
REQ-023 Word 5 = 0x8899AABB; store byte 0x11 to addr 0x15.
- RMW_RD cycle: read_addr=5.
- RMW_WR cycle: write_data=0x889911BB, write_addr=5.
- Memory word 5 = 0x889911BB afterwards.
REQ-024 Store word 0xDEADBEEF to addr 0x3FC -> a single memwrite cycle with write_addr=255; a following word load from 0x3FC returns 0xDEADBEEF.
REQ-025 Error cases -> resp_err=1 at N+1 with memread and memwrite never asserted:
- half load at 0x003;
- word store at 0x400;
- size 11.
REQ-026 Store half 0xCAFE to addr 0x02; assert rst in the RMW_RD cycle -> no memwrite, no resp_valid, memory word 0 unchanged, req_ready=1 on the first edge after rst is released.
REQ-027 Hold req_valid high continuously across back-to-back requests (load, store, load) -> each is accepted only when req_ready=1, and exactly three resp_valid pulses occur, in order.
